ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Host-side writer that fills the processor's program RAM before execution.
- Accepts 16-bit words over a valid/ready stream and writes them sequentially from physical address 0.
- Reads the image back and checks a checksum.
- Holds the processor in reset while loading, then releases it and pulses run.
- Owns the RAM port mux: loader drives the RAM while loading, the processor (post-TLB physical address) drives it while running.

Parameters:
ADDR_W, 6, physical RAM address width (matches TLB output)
DATA_W, 16, RAM/instruction word width
DEPTH, 64, number of RAM words (2**ADDR_W)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  begin a load session (sampled in IDLE, DONE, ERROR)
in_valid  input  1  host word valid
in_data  input  DATA_W  host word
in_last  input  1  marks final word of image
in_ready  output  1  loader accepts word this cycle
proc_addr  input  ADDR_W  processor physical address (from TLB)
proc_din  input  DATA_W  processor write data
proc_w  input  1  processor write enable
proc_done  input  1  processor done
ram_addr  output  ADDR_W  RAM address
ram_din  output  DATA_W  RAM write data
ram_w  output  1  RAM write enable
ram_q  input  DATA_W  RAM read data, valid 1 cycle after address
proc_resetN  output  1  processor reset, active low
proc_run  output  1  processor run pulse
word_count  output  ADDR_W+1  words written in last session
busy  output  1  state is LOAD, VERIFY or START
load_err  output  1  checksum mismatch
run_done  output  1  processor reported done

Behaviour:
- Reset: state IDLE. proc_resetN=0, proc_run=0, in_ready=0, ram_w=0, word_count=0, load_err=0, run_done=0, busy=0, write pointer and checksums cleared.
- States: IDLE, LOAD, VERIFY, START, RUN, DONE, ERROR.
- IDLE/DONE/ERROR, start=1 -> LOAD. Clears pointer, word_count, both sums, load_err and run_done.
- LOAD:
  - in_ready=1.
  - Handshake: transfer when in_valid&&in_ready. On transfer, in the same cycle: ram_addr=ptr, ram_din=in_data, ram_w=1. Then ptr+1, word_count+1, wsum+=in_data (16-bit wraparound).
  - in_valid=0: no write.
  - Exit to VERIFY after the transfer with in_last=1, or after the transfer to address DEPTH-1 (full). Further words are not accepted: in_ready=0 from the next cycle.
- VERIFY:
  - Issue reads to addresses 0..word_count-1, one per cycle, ram_w=0.
  - ram_q for address k is accumulated into rsum on the following cycle, so the last sample arrives one cycle after the last address.
  - Then compare: rsum==wsum -> START; otherwise -> ERROR (load_err=1).
  - Latency is word_count+2 cycles.
- START: proc_resetN=0 for this cycle. Next state RUN.
- RUN:
  - proc_resetN=1. proc_run=1 for exactly the first RUN cycle.
  - RAM port muxed to proc_addr/proc_din/proc_w.
  - proc_done=1 -> DONE (run_done=1). The RAM mux stays on the processor in DONE.
- ERROR: proc_resetN held 0. The RAM mux stays on the loader with ram_w=0.
- In every state except RUN/DONE, proc_w is ignored and the RAM is driven by the loader. The mux is registered on state only, never on proc_* inputs.
- start during LOAD/VERIFY/START/RUN: ignored.
- reset mid-LOAD: ram_w drops on the next cycle. A partially written image is not verified; the state returns to IDLE.
- Simultaneous in_last with ptr==DEPTH-1: a single transfer; go to VERIFY.
- word_count ranges 1..DEPTH. VERIFY is entered only after at least one transfer.

Decomposition:
- Shared package loader_pkg:
  - loader_state_t enum (7 states).
  - Constants ADDR_W=6, DATA_W=16, DEPTH=64.
  - Checksum width constant CSUM_W=16.
- Sub-module loader_bus_mux: selects loader vs processor RAM signals from a registered grant bit. Combinational, roughly 25 lines.

Test Plan:
- Load 3 words 0x0001, 0x0002, 0xFFFF with in_last on the third -> writes to addresses 0,1,2; word_count=3; wsum=0x0002; VERIFY 5 cycles; START; proc_run pulses 1 cycle; proc_resetN=1.
- Load with in_valid gaps (valid on alternate cycles), 4 words -> exactly 4 ram_w pulses at addresses 0..3; no writes in gap cycles.
- Stream 70 words without in_last -> 64 writes (addresses 0..63); in_ready=0 after the 64th; word_count=64; words 65-70 not accepted.
- RAM model corrupts address 1 on readback (xor 0x0010) -> load_err=1, state ERROR, proc_resetN stays 0, proc_run never asserted; start -> load_err clears.
- In RUN, processor writes 0x1234 to address 5, then proc_done=1 -> ram_addr=5, ram_din=0x1234, ram_w=1 passed through; run_done=1. proc_w asserted during LOAD has no effect on the RAM.
- Assert reset after 2 of 5 words -> next cycle: ram_w=0, in_ready=0, proc_resetN=0, word_count=0, state IDLE; start pressed during LOAD is ignored (word_count is not cleared).

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and sizing for the program-RAM loader.
// Sizes follow the processor's TLB output width and instruction word.
package loader_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CSUM_W = 16;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // One RAM port request: address, write data, write enable.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              w;
  } ram_req_t;

endpackage

// File: rtl/ram_loader_if.sv
// Host word stream into the loader (valid/ready with end-of-image marker).
interface ram_loader_if;
  import loader_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);

endinterface

// File: rtl/loader_bus_mux.sv
// RAM port select: loader or processor, chosen by a registered grant bit.
module loader_bus_mux
  import loader_pkg::*;
(
  input  logic     grant,
  input  ram_req_t ld_req,
  input  ram_req_t proc_req,
  output ram_req_t ram_req_c
);

  always_comb begin
    ram_req_c = ld_req;
    if (grant) begin
      ram_req_c = proc_req;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Fills program RAM from a host stream, verifies it by checksum readback,
// then releases the processor and hands it the RAM port.
module ram_loader
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  ram_loader_if.slave       host,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_din,
  input  logic              proc_w,
  input  logic              proc_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_w,
  input  logic [DATA_W-1:0] ram_q,
  output logic              proc_resetN,
  output logic              proc_run,
  output logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              load_err,
  output logic              run_done
);

  loader_state_t     state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  rptr;
  logic [CSUM_W-1:0] wsum, rsum;
  logic              ready_q, grant, sample_v;
  logic              xfer_c, issue_c, start_c;
  ram_req_t          ld_req, proc_req, ram_req_c;

  assign host.in_ready = ready_q;
  assign xfer_c  = host.in_valid && ready_q;
  assign issue_c = (state == ST_VERIFY) && (rptr < word_count);
  assign start_c = (state_d == ST_LOAD) && (state != ST_LOAD);

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (xfer_c && (host.in_last || ptr == ADDR_W'(DEPTH - 1))) begin
          state_d = ST_VERIFY;
        end
      end
      // Readback ends one cycle after the last sample lands in rsum
      ST_VERIFY: begin
        if (rptr == word_count + CNT_W'(1)) begin
          state_d = (rsum == wsum) ? ST_START : ST_ERROR;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (proc_done) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Loader-side RAM request: writes in LOAD, reads in VERIFY, idle otherwise
  always_comb begin
    ld_req = '0;
    if (state == ST_LOAD) begin
      ld_req.addr = ptr;
      ld_req.din  = host.in_data;
      ld_req.w    = xfer_c;
    end else if (state == ST_VERIFY) begin
      ld_req.addr = rptr[ADDR_W-1:0];
    end
  end

  always_comb begin
    proc_req      = '0;
    proc_req.addr = proc_addr;
    proc_req.din  = proc_din;
    proc_req.w    = proc_w;
  end

  loader_bus_mux u_mux (
    .grant     (grant),
    .ld_req    (ld_req),
    .proc_req  (proc_req),
    .ram_req_c (ram_req_c)
  );

  assign ram_addr = ram_req_c.addr;
  assign ram_din  = ram_req_c.din;
  assign ram_w    = ram_req_c.w;

  // Status outputs are registered from the next state so they align with state
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      rptr        <= '0;
      word_count  <= '0;
      wsum        <= '0;
      rsum        <= '0;
      sample_v    <= 1'b0;
      ready_q     <= 1'b0;
      grant       <= 1'b0;
      busy        <= 1'b0;
      proc_resetN <= 1'b0;
      proc_run    <= 1'b0;
      load_err    <= 1'b0;
      run_done    <= 1'b0;
    end else begin
      state       <= state_d;
      ready_q     <= (state_d == ST_LOAD);
      busy        <= (state_d inside {ST_LOAD, ST_VERIFY, ST_START});
      grant       <= (state_d inside {ST_RUN, ST_DONE});
      proc_resetN <= (state_d inside {ST_RUN, ST_DONE});
      proc_run    <= (state_d == ST_RUN) && (state != ST_RUN);
      sample_v    <= issue_c;
      if (start_c) begin
        ptr        <= '0;
        rptr       <= '0;
        word_count <= '0;
        wsum       <= '0;
        rsum       <= '0;
        load_err   <= 1'b0;
        run_done   <= 1'b0;
      end
      if (xfer_c) begin
        ptr        <= ptr + ADDR_W'(1);
        word_count <= word_count + CNT_W'(1);
        wsum       <= wsum + CSUM_W'(host.in_data);
      end
      if (state == ST_VERIFY) begin
        rptr <= rptr + CNT_W'(1);
        if (sample_v) rsum <= rsum + CSUM_W'(ram_q);
      end
      if (state == ST_VERIFY && state_d == ST_ERROR) load_err <= 1'b1;
      if (state == ST_RUN && state_d == ST_DONE) run_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: table of load sessions plus hand sequences
// for processor pass-through, ignored start and reset in the middle of a load.
module tb_ram_loader;
  import loader_pkg::*;

  logic              clock = 1'b0;
  logic              reset, start, proc_w, proc_done;
  logic [ADDR_W-1:0] proc_addr, ram_addr;
  logic [DATA_W-1:0] proc_din, ram_din, ram_q;
  logic              ram_w, proc_resetN, proc_run, busy, load_err, run_done;
  logic [CNT_W-1:0]  word_count;

  ram_loader_if host ();

  ram_loader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .host        (host),
    .proc_addr   (proc_addr),
    .proc_din    (proc_din),
    .proc_w      (proc_w),
    .proc_done   (proc_done),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_w       (ram_w),
    .ram_q       (ram_q),
    .proc_resetN (proc_resetN),
    .proc_run    (proc_run),
    .word_count  (word_count),
    .busy        (busy),
    .load_err    (load_err),
    .run_done    (run_done)
  );

  always #5 clock = ~clock;

  // RAM model with one-cycle read latency; optional readback corruption at address 1
  logic [DATA_W-1:0] mem [DEPTH];
  logic corrupt = 1'b0;
  logic clr_log = 1'b0;
  int   wr_n = 0;
  int   wr_addr [128];
  int   cyc = 0;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    ram_q <= mem[ram_addr] ^ ((corrupt && ram_addr == ADDR_W'(1)) ? 16'h0010 : 16'h0000);
    if (ram_w) mem[ram_addr] <= ram_din;
    if (clr_log) begin
      wr_n <= 0;
    end else if (ram_w) begin
      if (wr_n < 128) wr_addr[wr_n] <= int'(ram_addr);
      wr_n <= wr_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [15:0] seed, input int k);
    if (seed == 16'h0000) begin
      case (k)
        0: return 16'h0001;
        1: return 16'h0002;
        default: return 16'hFFFF;
      endcase
    end
    return seed + 16'(k) * 16'h1111;
  endfunction

  typedef struct {
    int          n;
    bit          gap;
    bit          last;
    bit          corr;
    logic [15:0] seed;
    int          exp_wc;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [6];

  task automatic run_session(input vec_t v, input bit finish_run);
    int   acc, off, t, last_cyc, n2, bad;
    logic rdy;
    acc = 0; off = 0; t = 0; last_cyc = 0; n2 = 0;
    @(negedge clock);
    clr_log = 1'b1; corrupt = v.corr; start = 1'b1;
    @(negedge clock);
    clr_log = 1'b0; start = 1'b0;
    chk("start_clears", {29'(word_count), load_err, run_done, 1'b0}, 32'h0);
    chk("load_ready", 32'(host.in_ready), 32'h1);
    while (off < v.n && t < 200) begin
      if (v.gap && (t % 2 == 1)) begin
        host.in_valid = 1'b0;
      end else begin
        host.in_valid = 1'b1;
        host.in_data  = word_of(v.seed, acc);
        host.in_last  = v.last && (acc == v.n - 1);
        off++;
      end
      rdy = host.in_ready;
      @(negedge clock);
      if (host.in_valid && rdy) begin
        acc++;
        last_cyc = cyc;
      end
      t++;
    end
    host.in_valid = 1'b0; host.in_last = 1'b0;
    while (!(proc_run || load_err) && n2 < 300) begin
      @(negedge clock);
      n2++;
    end
    chk("verify_latency", 32'(cyc - last_cyc), 32'(v.exp_lat));
    chk("word_count", 32'(word_count), 32'(v.exp_wc));
    chk("write_count", 32'(wr_n), 32'(v.exp_wc));
    bad = 0;
    for (int k = 0; k < wr_n && k < 128; k++) if (wr_addr[k] != k) bad++;
    chk("write_addr_order", 32'(bad), 32'h0);
    bad = 0;
    for (int k = 0; k < v.exp_wc; k++) if (mem[k] !== word_of(v.seed, k)) bad++;
    chk("ram_contents", 32'(bad), 32'h0);
    chk("load_err", 32'(load_err), 32'(v.exp_err));
    chk("proc_resetN", 32'(proc_resetN), 32'(!v.exp_err));
    chk("proc_run", 32'(proc_run), 32'(!v.exp_err));
    if (v.exp_err) begin
      bad = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (proc_resetN || proc_run || busy || ram_w || !load_err) bad++;
      end
      chk("error_hold", 32'(bad), 32'h0);
    end else begin
      @(negedge clock);
      chk("run_pulse_one_cycle", {30'h0, proc_run, proc_resetN}, 32'h1);
      if (finish_run) begin
        proc_done = 1'b1;
        @(negedge clock);
        proc_done = 1'b0;
        chk("run_done", {30'h0, run_done, busy}, 32'h2);
      end
    end
  endtask

  initial begin
    vt[0] = '{n: 3,  gap: 0, last: 1, corr: 0, seed: 16'h0000, exp_wc: 3,  exp_err: 0, exp_lat: 6};
    vt[1] = '{n: 4,  gap: 1, last: 1, corr: 0, seed: 16'h0100, exp_wc: 4,  exp_err: 0, exp_lat: 7};
    vt[2] = '{n: 70, gap: 0, last: 0, corr: 0, seed: 16'h0200, exp_wc: 64, exp_err: 0, exp_lat: 67};
    vt[3] = '{n: 5,  gap: 0, last: 1, corr: 1, seed: 16'h0300, exp_wc: 5,  exp_err: 1, exp_lat: 7};
    vt[4] = '{n: 64, gap: 0, last: 1, corr: 0, seed: 16'h0400, exp_wc: 64, exp_err: 0, exp_lat: 67};
    vt[5] = '{n: 1,  gap: 0, last: 1, corr: 0, seed: 16'h0500, exp_wc: 1,  exp_err: 0, exp_lat: 4};

    reset = 1'b1; start = 1'b0; proc_w = 1'b0; proc_done = 1'b0;
    proc_addr = '0; proc_din = '0;
    host.in_valid = 1'b0; host.in_data = '0; host.in_last = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {23'h0, proc_resetN, proc_run, host.in_ready, ram_w,
                          load_err, run_done, busy, 1'b0}, 32'h0);
    chk("reset_word_count", 32'(word_count), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_session(vt[i], 1'b1);

    // Processor owns the RAM port in RUN and DONE; start is ignored in RUN
    run_session('{n: 2, gap: 0, last: 1, corr: 0, seed: 16'h0700, exp_wc: 2,
                  exp_err: 0, exp_lat: 5}, 1'b0);
    proc_addr = 6'd5; proc_din = 16'h1234; proc_w = 1'b1;
    #1;
    chk("run_passthru", {9'h0, ram_addr, ram_din, ram_w}, {9'h0, 6'd5, 16'h1234, 1'b1});
    @(negedge clock);
    proc_w = 1'b0; start = 1'b1;
    chk("run_write_mem", 32'(mem[5]), 32'h1234);
    @(negedge clock);
    start = 1'b0;
    chk("start_ignored_run", {30'h0, busy, proc_resetN}, 32'h1);
    proc_done = 1'b1;
    @(negedge clock);
    proc_done = 1'b0; proc_addr = 6'd7;
    #1;
    chk("done_mux_proc", {30'h0, run_done, 1'b0}, 32'h2);
    chk("done_addr_passthru", 32'(ram_addr), 32'd7);

    // proc_w ignored during LOAD, start ignored during LOAD, reset mid-load
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0; proc_w = 1'b1; proc_addr = 6'd9; proc_din = 16'hDEAD;
    #1;
    chk("load_proc_w_ignored", 32'(ram_w), 32'h0);
    for (int k = 0; k < 2; k++) begin
      host.in_valid = 1'b1; host.in_data = 16'hA000 + 16'(k);
      #1;
      chk("load_addr_is_ptr", {15'h0, ram_addr, ram_w, ram_din[9:0]},
          {15'h0, 6'(k), 1'b1, 10'(k)});
      @(negedge clock);
    end
    host.in_valid = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_ignored_load", {24'h0, 7'(word_count), busy}, {24'h0, 7'd2, 1'b1});
    chk("mem9_untouched", 32'(mem[9]), 32'(word_of(16'h0400, 9)));
    host.in_valid = 1'b1; host.in_data = 16'hA002; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset_midload", {25'h0, ram_w, host.in_ready, proc_resetN, busy, 3'h0}, 32'h0);
    chk("reset_midload_wc", 32'(word_count), 32'h0);
    host.in_valid = 1'b0; proc_w = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", {30'h0, busy, ram_w}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
